// File: rtl/tape_rec.sv
// tape_rec: demodulates MSX 1200-baud cassette FSK into a .CAS image and writes it byte-wise to DDR3.
// RAM request is held until buff_mem_ready (>=2 cycles/byte); `define TAPE_REC_ERRCNT_EN enables frame_err_cnt_o.
module tape_rec #(
  parameter logic [27:0] BASE_ADDR  = 28'h0C00000,
  parameter int unsigned THRESH     = 1678,
  parameter int unsigned HDR_MIN    = 1024,
  parameter int unsigned SILENCE    = 8192,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        ce_5m3_i,
  input  logic        cas_in_i,
  input  logic        motor_i,
  input  logic        record_i,
  input  logic        rewind_i,
  output logic [27:0] ram_a_o,
  output logic [7:0]  ram_do_o,
  output logic        ram_wr_o,
  input  logic        buff_mem_ready_i,
  output logic [27:0] length_o,
  output logic        busy_o,
  output logic [7:0]  frame_err_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, PAD, HDR, SYNC, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        cas_q;
  logic [13:0] cnt_q;
  logic [15:0] run_q, run_d;
  logic [1:0]  half_q, half_d;
  logic        kind_q, kind_d;
  logic [2:0]  bitn_q, bitn_d, hidx_q, hidx_d;
  logic        stopn_q, stopn_d;
  logic [7:0]  sr_q, sr_d;
  logic        active, cas_edge, sym_l, sym_vld, sil_w;
  logic        bit_done, bit_val, bit_bad;
  logic        push, push_ok, pop, clr, rew_req, rew_pend_q, aligned;
  logic [7:0]  push_dat;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wp_q, rp_q, fifo_cnt;
  logic        fifo_full, fifo_empty;
  logic [2:0]  occ_lo;
  logic [27:0] length_q, ram_a_q;
  logic [7:0]  ram_do_q;
  logic        ram_wr_q;
`ifdef TAPE_REC_ERRCNT_EN
  logic        serr_q, serr_d, err_evt;
  logic [7:0]  err_q;
`endif

  function automatic logic [7:0] hdr_byte(input logic [2:0] i);
    case (i)
      3'd0: hdr_byte = 8'h1F;
      3'd1: hdr_byte = 8'hA6;
      3'd2: hdr_byte = 8'hDE;
      3'd3: hdr_byte = 8'hBA;
      3'd4: hdr_byte = 8'hCC;
      3'd5: hdr_byte = 8'h13;
      3'd6: hdr_byte = 8'h7D;
      default: hdr_byte = 8'h74;
    endcase
  endfunction

  assign active     = record_i & motor_i;
  assign cas_edge   = cas_in_i ^ cas_q;
  assign sym_l      = cnt_q >= 14'(THRESH);
  assign sym_vld    = cas_edge & active;
  // Counter saturates above SILENCE, so this fires exactly once per gap.
  assign sil_w      = ce_5m3_i & ~cas_edge & (cnt_q == 14'(SILENCE - 1));
  assign fifo_cnt   = wp_q - rp_q;
  assign fifo_empty = (wp_q == rp_q);
  assign fifo_full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign occ_lo     = length_q[2:0] + 3'(fifo_cnt);
  assign aligned    = (occ_lo == 3'd0);
  assign rew_req    = rewind_i | rew_pend_q;
  assign pop        = ram_wr_q & buff_mem_ready_i;
  assign clr        = rew_req & (~ram_wr_q | buff_mem_ready_i);
  assign push_ok    = push & ~fifo_full;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cas_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cas_q <= cas_in_i;
      if (cas_edge) cnt_q <= '0;
      else if (ce_5m3_i && cnt_q != '1) cnt_q <= cnt_q + 14'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    half_d   = half_q;
    kind_d   = kind_q;
    bitn_d   = bitn_q;
    hidx_d   = hidx_q;
    stopn_d  = stopn_q;
    sr_d     = sr_q;
    push     = 1'b0;
    push_dat = 8'h00;
    bit_done = 1'b0;
    bit_val  = 1'b0;
    bit_bad  = 1'b0;
`ifdef TAPE_REC_ERRCNT_EN
    serr_d   = serr_q;
    err_evt  = 1'b0;
`endif
    // '0' = two long halves, '1' = four short halves
    if (sym_vld && (state_q == SYNC || state_q == DATA || state_q == STOP)) begin
      if (half_q == 2'd0) begin
        kind_d = sym_l;
        half_d = 2'd1;
      end else if (sym_l != kind_q) begin
        bit_bad = 1'b1;
      end else if (kind_q || half_q == 2'd3) begin
        bit_done = 1'b1;
        bit_val  = ~kind_q;
        half_d   = 2'd0;
      end else begin
        half_d = half_q + 2'd1;
      end
    end
    case (state_q)
      IDLE: if (sym_vld) begin
        if (sym_l) run_d = '0;
        else if (run_q >= 16'(HDR_MIN - 1)) begin
          run_d   = '0;
          state_d = PAD;
        end else run_d = run_q + 16'd1;
      end
      PAD: begin
        if (aligned) begin
          state_d = HDR;
          hidx_d  = '0;
        end else if (!fifo_full) push = 1'b1;
      end
      HDR: if (!fifo_full) begin
        push     = 1'b1;
        push_dat = hdr_byte(hidx_q);
        hidx_d   = hidx_q + 3'd1;
        if (hidx_q == 3'd7) state_d = SYNC;
      end
      SYNC: if (sym_vld) begin
        if (half_q == 2'd0 && !sym_l) half_d = 2'd0;
        else if (bit_bad) state_d = IDLE;
        else if (bit_done) begin
          state_d = DATA;
          bitn_d  = '0;
        end
      end
      DATA: begin
        if (bit_bad) state_d = IDLE;
        else if (bit_done) begin
          sr_d   = {bit_val, sr_q[7:1]};
          bitn_d = bitn_q + 3'd1;
          if (bitn_q == 3'd7) begin
            state_d = STOP;
            stopn_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (bit_bad) state_d = IDLE;
        else if (bit_done) begin
          if (!stopn_q) begin
            stopn_d = 1'b1;
`ifdef TAPE_REC_ERRCNT_EN
            serr_d  = ~bit_val;
`endif
          end else begin
            push     = 1'b1;
            push_dat = sr_q;
            state_d  = SYNC;
`ifdef TAPE_REC_ERRCNT_EN
            err_evt  = serr_q | ~bit_val | fifo_full;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!active || rew_req) begin
      state_d = IDLE;
      push    = 1'b0;
`ifdef TAPE_REC_ERRCNT_EN
      err_evt = 1'b0;
`endif
    end else if (sil_w && state_q != IDLE) begin
      state_d = IDLE;
      push    = 1'b0;
    end
    if (state_d == IDLE) half_d = 2'd0;
    if ((state_q != IDLE && state_d == IDLE) || !active) run_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      run_q   <= '0;
      half_q  <= '0;
      kind_q  <= 1'b0;
      bitn_q  <= '0;
      hidx_q  <= '0;
      stopn_q <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      half_q  <= half_d;
      kind_q  <= kind_d;
      bitn_q  <= bitn_d;
      hidx_q  <= hidx_d;
      stopn_q <= stopn_d;
      sr_q    <= sr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wp_q[PW-1:0]] <= push_dat;
  end

  // A pending rewind waits for the in-flight write to be accepted before clearing.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wp_q       <= '0;
      rp_q       <= '0;
      length_q   <= '0;
      ram_a_q    <= BASE_ADDR;
      ram_do_q   <= 8'h00;
      ram_wr_q   <= 1'b0;
      rew_pend_q <= 1'b0;
    end else begin
      rew_pend_q <= rew_req & ~clr;
      if (clr) begin
        wp_q     <= '0;
        rp_q     <= '0;
        length_q <= '0;
        ram_wr_q <= 1'b0;
        ram_a_q  <= BASE_ADDR;
      end else begin
        if (push_ok) wp_q <= wp_q + 1'b1;
        if (pop) begin
          rp_q     <= rp_q + 1'b1;
          length_q <= length_q + 28'd1;
          ram_wr_q <= 1'b0;
        end else if (!ram_wr_q && !fifo_empty) begin
          ram_wr_q <= 1'b1;
          ram_do_q <= mem[rp_q[PW-1:0]];
          ram_a_q  <= BASE_ADDR + length_q;
        end
      end
    end
  end

`ifdef TAPE_REC_ERRCNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      serr_q <= 1'b0;
      err_q  <= 8'h00;
    end else begin
      serr_q <= serr_d;
      if (clr) err_q <= 8'h00;
      else if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end
  assign frame_err_cnt_o = err_q;
`else
  assign frame_err_cnt_o = 8'h00;
`endif

  assign ram_a_o  = ram_a_q;
  assign ram_do_o = ram_do_q;
  assign ram_wr_o = ram_wr_q;
  assign length_o = length_q;
  assign busy_o   = ram_wr_q | ~fifo_empty;

endmodule

// File: tb/tb_tape_rec.sv
// tb_tape_rec: drives FSK half-periods into tape_rec with shortened timing parameters and
// scores every DDR3 write against a queue of expected bytes filled as stimulus is generated.
module tb_tape_rec;
  localparam logic [27:0] BASE = 28'h0C00000;
  localparam int S_T   = 8;
  localparam int L_T   = 16;
  localparam int HDRN  = 32;
  localparam int SIL_T = 80;

  logic        clk = 1'b0, reset_n = 1'b0, ce = 1'b0, cas = 1'b0;
  logic        motor = 1'b0, record = 1'b0, rewind = 1'b0, rdy = 1'b0;
  logic [27:0] ram_a, length;
  logic [7:0]  ram_do, ferr;
  logic        ram_wr, busy;

  int          checks = 0, errors = 0;
  logic [7:0]  exp_q[$];
  int          exp_len = 0, exp_err = 0;
  bit          hold = 1'b0, stall_seen = 1'b0;
  logic [27:0] st_a;
  logic [7:0]  st_d;

  tape_rec #(.BASE_ADDR(BASE), .THRESH(12), .HDR_MIN(HDRN), .SILENCE(64), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .ce_5m3_i(ce), .cas_in_i(cas), .motor_i(motor),
    .record_i(record), .rewind_i(rewind), .ram_a_o(ram_a), .ram_do_o(ram_do), .ram_wr_o(ram_wr),
    .buff_mem_ready_i(rdy), .length_o(length), .busy_o(busy), .frame_err_cnt_o(ferr));

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    ce = ~ce;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] eferr();
`ifdef TAPE_REC_ERRCNT_EN
    return 32'(exp_err);
`else
    return 32'd0;
`endif
  endfunction

  // RAM side: acknowledge each write one cycle after it appears unless stalled.
  initial forever begin
    @(negedge clk);
    if (rdy) rdy = 1'b0;
    else if (reset_n && ram_wr) begin
      if (hold) begin
        if (!stall_seen) begin
          stall_seen = 1'b1;
          st_a = ram_a;
          st_d = ram_do;
        end else begin
          check("stall_addr", ram_a, st_a);
          check("stall_data", ram_do, st_d);
        end
      end else begin
        stall_seen = 1'b0;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("wr_addr", ram_a, BASE + 28'(exp_len));
          check("wr_data", ram_do, exp_q.pop_front());
          exp_len++;
        end
        rdy = 1'b1;
      end
    end
  end

  task automatic half(input int n);
    repeat (2 * n) @(negedge clk);
    cas = ~cas;
  endtask

  task automatic silence();
    repeat (2 * SIL_T) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    if (b) repeat (4) half(S_T);
    else repeat (2) half(L_T);
  endtask

  task automatic model_push(input logic [7:0] d, input bit serr);
    bit ovr;
    ovr = exp_q.size() >= 4;
    if (!ovr) exp_q.push_back(d);
    if (ovr || serr) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s1, input bit s2, input bit rec);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(s1);
    if (s2) repeat (3) half(S_T);
    else half(L_T);
    if (rec) model_push(d, !s1 || !s2);
    half(s2 ? S_T : L_T);
  endtask

  task automatic send_hdr();
    logic [7:0] hb [8];
    int pads;
    hb = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
    pads = (8 - ((exp_len + exp_q.size()) % 8)) % 8;
    repeat (pads) exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) exp_q.push_back(hb[i]);
    repeat (40) half(S_T);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, t < 3000, 1);
  endtask

  task automatic pulse_rewind();
    @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    exp_len = 0;
    exp_err = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ram_a", ram_a, BASE);
    check("rst_ram_do", ram_do, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_length", length, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", ferr, 0);
    reset_n = 1'b1;
    record  = 1'b1;
    motor   = 1'b1;

    // 1: header at offset 0 then one good byte
    send_hdr();
    send_byte(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_drain("t1_drain");
    check("t1_length", length, 9);
    check("t1_ferr", ferr, eferr());

    // 2: carrier loss, second block re-aligned with zero padding
    silence();
    send_hdr();
    wait_drain("t2_drain");
    check("t2_length", length, 24);

    // 3: first stop bit is '0'
    send_byte(8'h3C, 1'b0, 1'b1, 1'b1);
    wait_drain("t3_drain");
    check("t3_length", length, 25);
    check("t3_ferr", ferr, eferr());

    // 4: RAM stalls across a burst, last byte overruns the FIFO
    send_byte(8'h11, 1'b1, 1'b1, 1'b1);
    wait_drain("t4_first");
    hold = 1'b1;
    send_byte(8'h22, 1'b1, 1'b1, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1, 1'b1);
    send_byte(8'h66, 1'b1, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    check("t4_busy", busy, 1);
    check("t4_stall_a", ram_a, BASE + 28'(exp_len));
    check("t4_stall_d", ram_do, exp_q[0]);
    check("t4_ferr", ferr, eferr());
    hold = 1'b0;
    wait_drain("t4_drain");
    check("t4_length", length, 30);

    // 5: motor drops mid-byte; the queued byte still drains, the partial one never appears
    silence();
    send_hdr();
    wait_drain("t5_hdr");
    check("t5_hdr_len", length, 40);
    hold = 1'b1;
    send_byte(8'h77, 1'b1, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    motor = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    motor = 1'b1;
    send_byte(8'h99, 1'b1, 1'b1, 1'b0);
    check("t5_pending", ram_wr, 1);
    hold = 1'b0;
    wait_drain("t5_drain");
    check("t5_length", length, 41);
    check("t5_ferr", ferr, eferr());

    pulse_rewind();
    check("rew_length", length, 0);
    check("rew_ram_a", ram_a, BASE);
    check("rew_ferr", ferr, 0);
    check("rew_busy", busy, 0);

    // 6: asynchronous reset while a write is outstanding
    hold = 1'b1;
    silence();
    send_hdr();
    begin
      int t;
      t = 0;
      while (!ram_wr && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    check("t6_wr", ram_wr, 1);
    check("t6_busy", busy, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_ram_a", ram_a, BASE);
    check("t6_ram_do", ram_do, 0);
    check("t6_ram_wr", ram_wr, 0);
    check("t6_length", length, 0);
    check("t6_busy0", busy, 0);
    check("t6_ferr", ferr, 0);
    exp_q.delete();
    exp_len = 0;
    exp_err = 0;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pulse_rewind();
    check("t6_rew_len", length, 0);
    check("t6_rew_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
